pingpong_bank_scheduler: RTL and testbench
==========================================

# pingpong_bank_scheduler

Sequences the two 49-bit ping-pong block RAM banks between the UART receive path and the UART transmit path. It packs incoming 7-bit receive symbols into words and writes them into whichever bank is free. It tracks bank ownership with per-bank full flags and unpacks full banks back into 7-bit symbols over a ready/valid handshake toward the transmitter. It replaces ad-hoc bank switching in the top-level controller and drives both banks' address, write-enable and data pins directly.

## Interface
Parameters:
- N_DATA_BITS, 7, symbol width
- SYMS_PER_WORD, 7, symbols packed per RAM word; BRAM_WIDTH = N_DATA_BITS*SYMS_PER_WORD (49)
- ADDR_WIDTH, 15, RAM address width
- DEPTH, 32768, words per bank; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH

Ports:
- i_clk  in  1  single clock for all logic and both RAM ports
- i_reset_n  in  1  asynchronous, active-low reset
- i_rx_data  in  N_DATA_BITS  received symbol
- i_rx_valid  in  1  one-cycle strobe per received symbol
- o_rx_overflow  out  1  one-cycle pulse when a symbol is dropped
- o_wr_en  out  2  per-bank write enable, at most one bit high
- o_wr_addr  out  ADDR_WIDTH  write address, shared by both banks
- o_wr_data  out  BRAM_WIDTH  packed write word
- o_rd_addr  out  ADDR_WIDTH  read address, shared by both banks
- i_rd_data0 / i_rd_data1  in  BRAM_WIDTH  bank 0/1 read data, 1-cycle latency after o_rd_addr
- o_tx_data  out  N_DATA_BITS  symbol to transmitter
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts symbol
- o_bank_full  out  2  bank holds DEPTH unread words

## Operation
- State: wr_bank, wr_addr, sym_cnt (0..SYMS_PER_WORD-1), pack register, full[1:0], rd_bank, rd_addr, rd state machine.
- Writer, on i_rx_valid:
  - If full[wr_bank] is 1 (registered value): drop the symbol, pulse o_rx_overflow, leave sym_cnt and pack unchanged.
  - Otherwise shift the symbol into pack, MSB-first (first symbol lands in bits [48:42]), and increment sym_cnt.
  - On the SYMS_PER_WORD-th symbol: the next cycle drives o_wr_en[wr_bank]=1 for exactly one cycle with o_wr_addr=wr_addr and o_wr_data=pack. sym_cnt returns to 0.
  - After that write, if wr_addr==DEPTH-1: set full[wr_bank], toggle wr_bank, set wr_addr=0. Otherwise increment wr_addr.
- Reader FSM: IDLE, FETCH, WAIT, SEND.
  - IDLE: when full[rd_bank] is 1, go to FETCH.
  - FETCH: drive o_rd_addr=rd_addr, go to WAIT.
  - WAIT: capture i_rd_data{rd_bank} into the shift register, set idx=0, go to SEND.
  - SEND: o_tx_valid=1 and o_tx_data=current symbol, MSB-first. On i_tx_ready, advance idx.
    - After the last symbol, if rd_addr==DEPTH-1: clear full[rd_bank], toggle rd_bank, set rd_addr=0, go to IDLE.
    - Otherwise increment rd_addr and go to FETCH.
- Set/clear of full never targets the same bank in the same cycle: the writer owns only non-full banks and the reader only full ones. If the reader clears full[b] in the same cycle i_rx_valid arrives for bank b, that symbol is dropped, because the registered flag is used.
- Both banks full means the writer is stalled and every symbol is dropped until the reader frees a bank.
- Reset mid-operation: all state returns to reset values immediately. Partial words and bank contents are discarded logically; no RAM write is issued.

## Timing
- Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_rd_addr=0, o_tx_valid=0, o_tx_data=0, o_rx_overflow=0, o_bank_full=0, wr_bank=0, rd_bank=0, reader in IDLE.
- Write latency: o_wr_en rises one cycle after the strobe carrying the final symbol.
- o_bank_full[b] rises the cycle after the last write to bank b.
- Reader start: FETCH is entered the cycle after full rises. The first o_tx_valid appears 3 cycles after o_bank_full rises (IDLE→FETCH→WAIT→SEND).
- Handshake:
  - A symbol transfers on a cycle with o_tx_valid & i_tx_ready.
  - o_tx_data holds stable while o_tx_valid=1 and i_tx_ready=0.
  - o_tx_valid never drops without a transfer, except on reset.
- Throughput with i_tx_ready held high: SYMS_PER_WORD+2 cycles per word (9 at defaults).
- o_bank_full[b] falls the cycle after the final symbol of bank b transfers.
- o_rx_overflow is combinationally-free: registered, one cycle after the dropped strobe.

## Test plan
- DEPTH=4, i_tx_ready=0: send 28 symbols 0x01..0x1C. Expect 4 writes to bank 0, with word 0 = {01,02,03,04,05,06,07}, then o_bank_full=2'b01 and wr_bank=1.
- Same run, then i_tx_ready=1. Expect 28 tx symbols 0x01..0x1C in order, o_bank_full returning to 0, and 9 cycles per word.
- DEPTH=4, i_tx_ready=0: send 57 symbols. Both banks fill; symbol 57 is dropped with an o_rx_overflow pulse and no o_wr_en.
- Backpressure: toggle i_tx_ready randomly while draining. o_tx_data stays stable while stalled, and no symbol is lost or duplicated.
- Continuous streaming, DEPTH=4: 560 symbols at one per 10 cycles with ready high. Output equals input, and o_rx_overflow never pulses.
- Reset: assert i_reset_n=0 after 3 symbols of a word and again mid-SEND. All outputs return to reset values; after release, the next 7 symbols form word 0 of bank 0.

Source files
------------

// File: rtl/pingpong_bank_scheduler.sv
// pingpong_bank_scheduler: packs rx symbols into two ping-pong RAM banks and
// drains full banks symbol by symbol toward the transmitter.
module pingpong_bank_scheduler #(
    parameter int N_DATA_BITS   = 7,
    parameter int SYMS_PER_WORD = 7,
    parameter int ADDR_WIDTH    = 15,
    parameter int DEPTH         = 32768,
    localparam int BRAM_WIDTH   = N_DATA_BITS * SYMS_PER_WORD
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [N_DATA_BITS-1:0] i_rx_data,
    input  logic                   i_rx_valid,
    output logic                   o_rx_overflow,
    output logic [1:0]             o_wr_en,
    output logic [ADDR_WIDTH-1:0]  o_wr_addr,
    output logic [BRAM_WIDTH-1:0]  o_wr_data,
    output logic [ADDR_WIDTH-1:0]  o_rd_addr,
    input  logic [BRAM_WIDTH-1:0]  i_rd_data0,
    input  logic [BRAM_WIDTH-1:0]  i_rd_data1,
    output logic [N_DATA_BITS-1:0] o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic [1:0]             o_bank_full
);
    localparam int CW = $clog2(SYMS_PER_WORD);
    localparam logic [CW-1:0] LAST_SYM = CW'(SYMS_PER_WORD - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} rd_state_t;

    rd_state_t state;
    logic wr_bank, rd_bank, wr_last, rd_last;
    logic [1:0] full, full_set, full_clr;
    logic [CW-1:0] sym_cnt, idx;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [BRAM_WIDTH-1:0] pack, shift;

    assign wr_last = |o_wr_en && wr_addr == LAST_ADDR;
    assign rd_last = state == SEND && i_tx_ready && idx == LAST_SYM && rd_addr == LAST_ADDR;
    assign full_set = wr_last ? 2'b01 << wr_bank : 2'b00;
    assign full_clr = rd_last ? 2'b01 << rd_bank : 2'b00;
    assign o_wr_addr = wr_addr;
    assign o_wr_data = pack;
    assign o_rd_addr = rd_addr;
    assign o_bank_full = full;
    assign o_tx_valid = state == SEND;
    assign o_tx_data = shift[BRAM_WIDTH-1 -: N_DATA_BITS];

    // Writer: pack is only ever shifted, so it still holds the finished word during the write cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rx_overflow <= 1'b0;
            o_wr_en <= 2'b00;
            pack <= '0;
            sym_cnt <= '0;
            wr_addr <= '0;
            wr_bank <= 1'b0;
            full <= 2'b00;
        end else begin
            o_rx_overflow <= i_rx_valid && full[wr_bank];
            o_wr_en <= 2'b00;
            if (i_rx_valid && !full[wr_bank]) begin
                pack <= {pack[BRAM_WIDTH-N_DATA_BITS-1:0], i_rx_data};
                sym_cnt <= sym_cnt == LAST_SYM ? '0 : sym_cnt + 1'b1;
                if (sym_cnt == LAST_SYM) o_wr_en <= 2'b01 << wr_bank;
            end
            if (|o_wr_en) begin
                wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
                if (wr_last) wr_bank <= ~wr_bank;
            end
            full <= (full | full_set) & ~full_clr;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            rd_bank <= 1'b0;
            rd_addr <= '0;
            idx <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE:  if (full[rd_bank]) state <= FETCH;
                FETCH: state <= WAIT;
                WAIT: begin
                    shift <= rd_bank ? i_rd_data1 : i_rd_data0;
                    idx <= '0;
                    state <= SEND;
                end
                SEND: if (i_tx_ready) begin
                    shift <= shift << N_DATA_BITS;
                    idx <= idx + 1'b1;
                    if (idx == LAST_SYM) begin
                        state <= rd_last ? IDLE : FETCH;
                        rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
                        if (rd_last) rd_bank <= ~rd_bank;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pingpong_bank_scheduler.sv
// tb_pingpong_bank_scheduler: queue-based scoreboard with a behavioural RAM
// model; symbols in must reappear as RAM words and tx symbols in order.
module tb_pingpong_bank_scheduler;
    localparam int SPW = 7, AW = 15, DEPTH = 4, BW = 49;

    logic i_clk = 1'b0, i_reset_n = 1'b1, i_rx_valid = 1'b0, i_tx_ready = 1'b0;
    logic [6:0] i_rx_data = '0;
    logic o_rx_overflow, o_tx_valid;
    logic [1:0] o_wr_en, o_bank_full;
    logic [AW-1:0] o_wr_addr, o_rd_addr;
    logic [BW-1:0] o_wr_data, i_rd_data0, i_rd_data1, rq0, rq1, wexp, w0;
    logic [6:0] o_tx_data, prev_d;

    pingpong_bank_scheduler #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_rx_overflow(o_rx_overflow), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_rd_addr(o_rd_addr), .i_rd_data0(i_rd_data0),
        .i_rd_data1(i_rd_data1), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready), .o_bank_full(o_bank_full)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0, errors = 0;
    int widx = 0, n_wr = 0, n_ovf = 0, n_stall_err = 0, cyc = 0, tp_last = 0, tx_cnt = 0;
    bit tp_on = 0, prev_v = 0, prev_r = 0;
    logic [1:0] last_wr;
    logic last_ovf;
    logic [6:0] wq[$], txq[$];
    logic [BW-1:0] mem[2][DEPTH];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    assign i_rd_data0 = rq0;
    assign i_rd_data1 = rq1;

    always @(posedge i_clk) begin
        cyc++;
        rq0 <= mem[0][int'(o_rd_addr) % DEPTH];
        rq1 <= mem[1][int'(o_rd_addr) % DEPTH];
    end

    // Word n of a run belongs to bank (n/DEPTH)%2 at address n%DEPTH.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_rx_overflow) n_ovf++;
            if (o_wr_en != 2'b00) begin
                n_wr++;
                check("wr_onehot", 64'($countones(o_wr_en)), 1);
                check("wr_bank", o_wr_en, ((widx / DEPTH) % 2) != 0 ? 2'b10 : 2'b01);
                check("wr_addr", o_wr_addr, widx % DEPTH);
                wexp = '0;
                for (int k = 0; k < SPW; k++) wexp = {wexp[BW-8:0], wq.size() != 0 ? wq.pop_front() : 7'h0};
                check("wr_data", o_wr_data, wexp);
                mem[o_wr_en[1]][int'(o_wr_addr) % DEPTH] = o_wr_data;
                widx++;
            end
            if (prev_v && !prev_r && !(o_tx_valid && o_tx_data == prev_d)) n_stall_err++;
            if (o_tx_valid && i_tx_ready) begin
                if (txq.size() == 0) check("tx_unexpected", o_tx_valid, 0);
                else check("tx_data", o_tx_data, txq.pop_front());
                if (tp_on && tx_cnt % SPW == 0 && tx_cnt > 0) check("word_period", cyc - tp_last, 9);
                if (tx_cnt % SPW == 0) tp_last = cyc;
                tx_cnt++;
            end
            prev_v = o_tx_valid;
            prev_r = i_tx_ready;
            prev_d = o_tx_data;
        end else prev_v = 0;
    end

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_rx_valid = 1'b0;
        #1;
        check("rst_wr_en", o_wr_en, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_rd_addr", o_rd_addr, 0);
        check("rst_tx_valid", o_tx_valid, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_ovf", o_rx_overflow, 0);
        check("rst_full", o_bank_full, 0);
        wq.delete();
        txq.delete();
        widx = 0; n_wr = 0; n_ovf = 0; n_stall_err = 0; tx_cnt = 0;
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
    endtask

    task automatic send(input logic [6:0] d, input bit acc, input int gap);
        i_rx_data = d;
        i_rx_valid = 1'b1;
        if (acc) begin
            wq.push_back(d);
            txq.push_back(d);
        end
        @(posedge i_clk);
        #1 i_rx_valid = 1'b0;
        @(negedge i_clk);
        last_wr = o_wr_en;
        last_ovf = o_rx_overflow;
        repeat (gap - 1) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_full(input logic [1:0] mask);
        int t = 0;
        while (o_bank_full != mask && t < 100) begin
            @(posedge i_clk);
            #1 t++;
        end
        check("bank_full", o_bank_full, mask);
    endtask

    task automatic drain(input bit rnd, input int bound);
        int t = 0;
        while (txq.size() != 0 && t < bound) begin
            if (rnd) i_tx_ready = 1'($urandom_range(0, 1));
            @(posedge i_clk);
            #1 t++;
        end
        check("drain_done", txq.size(), 0);
    endtask

    initial begin
        do_reset();
        // Fill bank 0 with the transmitter stalled, then drain at full rate.
        for (int i = 1; i <= 28; i++) begin
            send(7'(i), 1, 2);
            if (i == 7) check("wr_latency", last_wr, 2'b01);
        end
        wait_full(2'b01);
        begin
            int k = 0;
            while (!o_tx_valid && k < 10) begin
                @(posedge i_clk);
                #1 k++;
            end
            check("tx_start", k, 3);
        end
        check("bank0_writes", n_wr, 4);
        w0 = '0;
        for (int k = 1; k <= 7; k++) w0 = {w0[BW-8:0], 7'(k)};
        check("word0", mem[0][0], w0);
        tp_on = 1;
        i_tx_ready = 1'b1;
        drain(0, 200);
        tp_on = 0;
        check("full_clear", o_bank_full, 0);

        // Overflow with both banks full, then drain under random backpressure.
        do_reset();
        i_tx_ready = 1'b0;
        for (int i = 1; i <= 57; i++) send(7'(i), i <= 56, 2);
        check("ovf_pulse", last_ovf, 1);
        check("ovf_no_write", last_wr, 0);
        check("both_full", o_bank_full, 2'b11);
        check("ovf_count", n_ovf, 1);
        check("writes_56", n_wr, 8);
        drain(1, 3000);
        check("stall_hold", n_stall_err, 0);
        i_tx_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 check("full_clear2", o_bank_full, 0);

        // Continuous streaming.
        do_reset();
        i_tx_ready = 1'b1;
        for (int i = 0; i < 560; i++) send(7'($urandom), 1, 10);
        drain(0, 500);
        check("stream_ovf", n_ovf, 0);
        check("stream_writes", n_wr, 80);

        // Reset after a partial word, then mid-SEND.
        for (int i = 0; i < 3; i++) send(7'($urandom), 1, 2);
        do_reset();
        for (int i = 0; i < 7; i++) send(7'(8'h40 + i), 1, 2);
        check("post_reset_writes", n_wr, 1);
        i_tx_ready = 1'b0;
        for (int i = 0; i < 21; i++) send(7'($urandom), 1, 2);
        wait_full(2'b01);
        repeat (5) @(posedge i_clk);
        #1 check("in_send", o_tx_valid, 1);
        do_reset();
        for (int i = 0; i < 7; i++) send(7'(i + 3), 1, 2);
        repeat (5) @(posedge i_clk);
        #1;
        check("send_reset_writes", n_wr, 1);
        check("send_reset_full", o_bank_full, 0);
        check("send_reset_tx", o_tx_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
